// File: rtl/if_id_queue_pkg.sv
// Shared constants and pointer-wrap helper for the IF/ID instruction queue.
package if_id_queue_pkg;

   localparam int unsigned NB_BITS     = 32;
   localparam int unsigned IF_ID_DEPTH = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

   // Next pointer value with an explicit wrap, so DEPTH need not be a power of two.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/if_id_ptr.sv
// Queue pointer register: increment with wrap at DEPTH-1, or load an absolute value.
module if_id_ptr
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = IF_ID_DEPTH,
   parameter int unsigned NB_PTR = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_inc,
   input  logic              i_load,
   input  logic [NB_PTR-1:0] i_load_ptr,
   output logic [NB_PTR-1:0] o_ptr
);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ptr <= '0;
      end else if (i_load) begin
         o_ptr <= i_load_ptr;
      end else if (i_inc) begin
         o_ptr <= NB_PTR'(ptr_next(32'(o_ptr), DEPTH));
      end
   end

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with first-word fall-through and full flush.
// Optional IF_ID_QUEUE_PERF_EN adds saturating stall and flush counters.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned          NB_BITS   = if_id_queue_pkg::NB_BITS,
   parameter int unsigned          DEPTH     = IF_ID_DEPTH,
   parameter logic [NB_BITS-1:0]   NOP_INSTR = NB_BITS'(if_id_queue_pkg::NOP_INSTR),
   parameter int unsigned          NB_CNT    = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_BITS-1:0] i_pc,
   input  logic [NB_BITS-1:0] i_instr,
   input  logic               i_push,
   output logic               o_ready,
   output logic [NB_BITS-1:0] o_if_id_pc,
   output logic [NB_BITS-1:0] o_if_id_instr,
   output logic               o_valid,
   input  logic               i_pop,
   input  logic               i_ctr_flush,
   output logic [NB_CNT-1:0]  o_count
`ifdef IF_ID_QUEUE_PERF_EN
   ,
   output logic [NB_BITS-1:0] o_stall_cnt,
   output logic [NB_BITS-1:0] o_flush_cnt
`endif
);

   localparam int unsigned NB_PTR = $clog2(DEPTH);

   logic [NB_BITS-1:0] mem_pc    [DEPTH];
   logic [NB_BITS-1:0] mem_instr [DEPTH];
   logic [NB_CNT-1:0]  count;
   logic [NB_PTR-1:0]  wr_ptr;
   logic [NB_PTR-1:0]  rd_ptr;
   logic               push_acc;
   logic               pop_acc;

   assign o_ready  = (count != NB_CNT'(DEPTH));
   assign o_valid  = (count != '0);
   assign push_acc = i_push && o_ready && !i_ctr_flush;
   assign pop_acc  = i_pop && o_valid && !i_ctr_flush;
   assign o_count  = count;

   // Head entry falls through; an empty queue presents a NOP at pc 0.
   assign o_if_id_pc    = o_valid ? mem_pc[rd_ptr]    : '0;
   assign o_if_id_instr = o_valid ? mem_instr[rd_ptr] : NOP_INSTR;

   if_id_ptr #(.DEPTH(DEPTH), .NB_PTR(NB_PTR)) u_wr_ptr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_inc      (push_acc),
      .i_load     (1'b0),
      .i_load_ptr ('0),
      .o_ptr      (wr_ptr)
   );

   // Flush empties the queue by snapping the read pointer onto the write pointer.
   if_id_ptr #(.DEPTH(DEPTH), .NB_PTR(NB_PTR)) u_rd_ptr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_inc      (pop_acc),
      .i_load     (i_ctr_flush),
      .i_load_ptr (wr_ptr),
      .o_ptr      (rd_ptr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || i_ctr_flush) begin
         count <= '0;
      end else if (push_acc && !pop_acc) begin
         count <= count + NB_CNT'(1);
      end else if (pop_acc && !push_acc) begin
         count <= count - NB_CNT'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && push_acc) begin
         mem_pc[wr_ptr]    <= i_pc;
         mem_instr[wr_ptr] <= i_instr;
      end
   end

`ifdef IF_ID_QUEUE_PERF_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (i_push && !o_ready && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + NB_BITS'(1);
         end
         if (i_ctr_flush && (o_flush_cnt != '1)) begin
            o_flush_cnt <= o_flush_cnt + NB_BITS'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

   localparam int unsigned NB_BITS = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned NB_CNT  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP     = 32'h0000_0000;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic [NB_BITS-1:0] i_pc;
   logic [NB_BITS-1:0] i_instr;
   logic               i_push;
   logic               o_ready;
   logic [NB_BITS-1:0] o_if_id_pc;
   logic [NB_BITS-1:0] o_if_id_instr;
   logic               o_valid;
   logic               i_pop;
   logic               i_ctr_flush;
   logic [NB_CNT-1:0]  o_count;
`ifdef IF_ID_QUEUE_PERF_EN
   logic [NB_BITS-1:0] o_stall_cnt;
   logic [NB_BITS-1:0] o_flush_cnt;
`endif

   always #5 i_clk = ~i_clk;

   if_id_queue dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_pc          (i_pc),
      .i_instr       (i_instr),
      .i_push        (i_push),
      .o_ready       (o_ready),
      .o_if_id_pc    (o_if_id_pc),
      .o_if_id_instr (o_if_id_instr),
      .o_valid       (o_valid),
      .i_pop         (i_pop),
      .i_ctr_flush   (i_ctr_flush),
      .o_count       (o_count)
`ifdef IF_ID_QUEUE_PERF_EN
      ,
      .o_stall_cnt   (o_stall_cnt),
      .o_flush_cnt   (o_flush_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      model_q[$];
   int unsigned model_stall;
   int unsigned model_flush;
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int unsigned n;
      n = model_q.size();
      check("valid", 64'(o_valid), 64'(n != 0));
      check("ready", 64'(o_ready), 64'(n != DEPTH));
      check("count", 64'(o_count), 64'(n));
      check("head_pc", 64'(o_if_id_pc), (n != 0) ? 64'(model_q[0].pc) : 64'd0);
      check("head_instr", 64'(o_if_id_instr), (n != 0) ? 64'(model_q[0].instr) : 64'(NOP));
`ifdef IF_ID_QUEUE_PERF_EN
      check("stall_cnt", 64'(o_stall_cnt), 64'(model_stall));
      check("flush_cnt", 64'(o_flush_cnt), 64'(model_flush));
`endif
   endtask

   // Reference behaviour at one clock edge, evaluated on the pre-edge occupancy.
   task automatic model_edge(input logic rst, input logic push, input logic [31:0] pc,
                             input logic [31:0] instr, input logic pop, input logic flush);
      entry_t e;
      int unsigned n;
      n = model_q.size();
      if (rst) begin
         model_q.delete();
         model_stall = 0;
         model_flush = 0;
      end else begin
         if (push && n == DEPTH) model_stall++;
         if (flush) begin
            model_q.delete();
            model_flush++;
         end else begin
            if (pop && n > 0) void'(model_q.pop_front());
            if (push && n < DEPTH) begin
               e.pc    = pc;
               e.instr = instr;
               model_q.push_back(e);
            end
         end
      end
   endtask

   // Drive one cycle's inputs at the falling edge, clock them in, then check mid-low phase.
   task automatic step(input logic rst, input logic push, input logic [31:0] pc,
                       input logic [31:0] instr, input logic pop, input logic flush);
      i_rst       = rst;
      i_push      = push;
      i_pc        = pc;
      i_instr     = instr;
      i_pop       = pop;
      i_ctr_flush = flush;
      @(posedge i_clk);
      model_edge(rst, push, pc, instr, pop, flush);
      @(negedge i_clk);
      check_all();
   endtask

   task automatic push_one(input logic [31:0] pc);
      step(1'b0, 1'b1, pc, 32'h2001_0000 | pc, 1'b0, 1'b0);
   endtask

   initial begin
      i_rst = 1'b1; i_push = 1'b0; i_pop = 1'b0; i_ctr_flush = 1'b0;
      i_pc = '0; i_instr = '0;
      @(negedge i_clk);

      step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      check("reset_valid", 64'(o_valid), 64'd0);
      check("reset_instr", 64'(o_if_id_instr), 64'h0);
      check("reset_ready", 64'(o_ready), 64'd1);

      step(1'b0, 1'b1, 32'd4, 32'h2001_0001, 1'b0, 1'b0);
      check("first_pc", 64'(o_if_id_pc), 64'd4);
      check("first_count", 64'(o_count), 64'd1);

      // Fill past capacity; the fifth push is refused.
      step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) push_one(32'(4 * k));
      check("full_ready", 64'(o_ready), 64'd0);
      check("full_count", 64'(o_count), 64'd4);
      for (int k = 1; k <= 4; k++) begin
         check("drain_head", 64'(o_if_id_pc), 64'(4 * k));
         step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      end
      check("drain_valid", 64'(o_valid), 64'd0);

      // Push+pop when full, then at count 3 across the pointer wrap.
      for (int k = 1; k <= 4; k++) push_one(32'(4 * k));
      step(1'b0, 1'b1, 32'd100, 32'h100, 1'b1, 1'b0);
      check("full_pp_count", 64'(o_count), 64'd3);
      step(1'b0, 1'b1, 32'd104, 32'h104, 1'b1, 1'b0);
      check("pp_count", 64'(o_count), 64'd3);
      check("pp_head", 64'(o_if_id_pc), 64'd12);

      // Flush wins over a simultaneous push and pop.
      step(1'b0, 1'b1, 32'd108, 32'h108, 1'b1, 1'b1);
      check("flush_count", 64'(o_count), 64'd0);
      push_one(32'd40);
      check("after_flush_head", 64'(o_if_id_pc), 64'd40);

      push_one(32'd44);
      step(1'b1, 1'b1, 32'd48, 32'h48, 1'b0, 1'b0);
      check("rst_mid_count", 64'(o_count), 64'd0);

`ifdef IF_ID_QUEUE_PERF_EN
      for (int k = 1; k <= 4; k++) push_one(32'(4 * k));
      for (int k = 0; k < 3; k++) push_one(32'd200);
      check("stall_three", 64'(o_stall_cnt), 64'd3);
      step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
`endif

      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(99) < 2), ($urandom_range(99) < 60), $urandom, $urandom,
              ($urandom_range(99) < 50), ($urandom_range(99) < 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
